// File: rtl/deck_dealer_if.sv
// -----------------------------------------------------------------------------
// deck_dealer_if
//   Bundles the request/response signals between the blackjack controller
//   (master) and the card source deck_dealer (slave).
//
//   Controller -> dealer:
//     seed[5:0]             shuffle seed, captured when a shuffle is accepted
//     shuffle_start         one-cycle request to reinitialise and shuffle
//     deal_req              one-cycle request for the next card
//   Dealer -> controller:
//     card_valid            one-cycle pulse, card/card_rank/card_value valid
//     card[5:0]             card index 0..51 (suit = card/13, rank = card%13+1)
//     card_rank[3:0]        1..13
//     card_value[3:0]       blackjack points (ace=1, J/Q/K=10)
//     shuffle_busy          high while a shuffle is in progress
//     shuffle_done          one-cycle pulse when a shuffle completes
//     cards_remaining[5:0]  undealt cards
//     deck_empty            cards_remaining == 0
//     deck_low              cards_remaining below the low threshold
// -----------------------------------------------------------------------------
interface deck_dealer_if;
  logic [5:0] seed;
  logic       shuffle_start;
  logic       deal_req;

  logic       card_valid;
  logic [5:0] card;
  logic [3:0] card_rank;
  logic [3:0] card_value;
  logic       shuffle_busy;
  logic       shuffle_done;
  logic [5:0] cards_remaining;
  logic       deck_empty;
  logic       deck_low;

  modport master (
    output seed, shuffle_start, deal_req,
    input  card_valid, card, card_rank, card_value,
    input  shuffle_busy, shuffle_done, cards_remaining, deck_empty, deck_low
  );

  modport slave (
    input  seed, shuffle_start, deal_req,
    output card_valid, card, card_rank, card_value,
    output shuffle_busy, shuffle_done, cards_remaining, deck_empty, deck_low
  );
endinterface

// File: rtl/deck_dealer.sv
// -----------------------------------------------------------------------------
// deck_dealer
//   Card source for the blackjack controller. Keeps a 52-card deck in a
//   register array, shuffles it with a seeded Fisher-Yates pass driven by a
//   16-bit Galois LFSR, and answers each accepted deal request with one
//   registered card plus its rank and blackjack value.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   deck_dealer_if.slave (see deck_dealer_if.sv for signal list)
//
//   Shuffle sequence: READY -> SHUF_LOAD (deck to identity, LFSR seeded)
//   -> SHUF_RUN (one candidate swap per cycle, i = 51 down to 1)
//   -> SHUF_DONE (one-cycle done pulse, deck refilled) -> READY.
//   Requests arriving outside READY are dropped; shuffle_start beats a
//   simultaneous deal_req.
//
//   Optional build macro AUTO_RESHUFFLE_EN: a deal request on an empty deck
//   is remembered, the deck is reset to identity and shuffled straight away
//   (continuing the current LFSR sequence, no reseed), and the pending card
//   is delivered on the cycle after the done pulse. Without the macro such a
//   request is simply dropped.
// -----------------------------------------------------------------------------
module deck_dealer #(
  parameter int DECK_SIZE     = 52,
  parameter int LOW_THRESHOLD = 10
) (
  input  logic         clk,
  input  logic         rst,
  deck_dealer_if.slave bus
);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    SHUF_LOAD = 2'd1,
    SHUF_RUN  = 2'd2,
    SHUF_DONE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [5:0]  FULL_COUNT = 6'(DECK_SIZE);
  localparam logic [5:0]  LAST_IDX   = 6'(DECK_SIZE - 1);
  localparam logic [5:0]  LOW_LEVEL  = 6'(LOW_THRESHOLD);

  // Smallest 2^n-1 covering i, so the masked LFSR value can reach every
  // legal swap partner 0..i with as few rejected draws as possible.
  function automatic logic [5:0] idx_mask(input logic [5:0] i);
    if (i >= 6'd32)      return 6'd63;
    else if (i >= 6'd16) return 6'd31;
    else if (i >= 6'd8)  return 6'd15;
    else if (i >= 6'd4)  return 6'd7;
    else if (i >= 6'd2)  return 6'd3;
    else                 return 6'd1;
  endfunction

  // rank = card % 13 + 1, done with three compares instead of a divider.
  function automatic logic [3:0] rank_of(input logic [5:0] c);
    logic [5:0] r;
    if (c >= 6'd39)      r = c - 6'd39;
    else if (c >= 6'd26) r = c - 6'd26;
    else if (c >= 6'd13) r = c - 6'd13;
    else                 r = c;
    return 4'(r + 6'd1);
  endfunction

  function automatic logic [3:0] value_of(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_next;
  logic [5:0]  deck [DECK_SIZE];
  logic [5:0]  ptr;
  logic [5:0]  remaining;
  logic [5:0]  idx_i;
  logic [15:0] lfsr;
  logic [5:0]  seed_q;

  logic        card_valid_q;
  logic [5:0]  card_q;
  logic [3:0]  rank_q;
  logic [3:0]  value_q;
  logic        busy_q;
  logic        done_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [5:0]  j_idx;
  logic        swap_ok;
  logic        last_swap;
  logic [15:0] lfsr_step;
  logic [5:0]  head_card;
  logic [3:0]  head_rank;
  logic        accept_shuffle;
  logic        accept_deal;
  logic        load_identity;
  logic        deliver;

  assign j_idx     = lfsr[5:0] & idx_mask(idx_i);
  assign swap_ok   = (j_idx <= idx_i);
  assign last_swap = swap_ok && (idx_i == 6'd1);
  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  assign head_card = deck[ptr];
  assign head_rank = rank_of(head_card);

`ifdef AUTO_RESHUFFLE_EN
  logic auto_start;
  logic pending;

  assign load_identity = (state == SHUF_LOAD) || auto_start;
  assign deliver       = accept_deal || ((state == SHUF_DONE) && pending);
`else
  assign load_identity = (state == SHUF_LOAD);
  assign deliver       = accept_deal;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    accept_shuffle = 1'b0;
    accept_deal    = 1'b0;
`ifdef AUTO_RESHUFFLE_EN
    auto_start     = 1'b0;
`endif
    case (state)
      READY: begin
        if (bus.shuffle_start) begin
          accept_shuffle = 1'b1;
          state_next     = SHUF_LOAD;
        end else if (bus.deal_req) begin
          if (remaining != 6'd0) begin
            accept_deal = 1'b1;
          end
`ifdef AUTO_RESHUFFLE_EN
          else begin
            auto_start = 1'b1;
            state_next = SHUF_RUN;
          end
`endif
        end
      end
      SHUF_LOAD: state_next = SHUF_RUN;
      SHUF_RUN:  if (last_swap) state_next = SHUF_DONE;
      SHUF_DONE: state_next = READY;
      default:   state_next = READY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= READY;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      seed_q <= 6'd0;
      lfsr   <= LFSR_RESET;
      idx_i  <= 6'd0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next == SHUF_LOAD) || (state_next == SHUF_RUN);
      done_q <= (state_next == SHUF_DONE);

      if (accept_shuffle) seed_q <= bus.seed;

      // Seed layout {seed, ~seed, 4'hA} always has set bits, so the LFSR
      // can never lock up at zero.
      if (state == SHUF_LOAD)     lfsr <= {seed_q, ~seed_q, 4'hA};
      else if (state == SHUF_RUN) lfsr <= lfsr_step;

      if (load_identity)                    idx_i <= LAST_IDX;
      else if (state == SHUF_RUN && swap_ok) idx_i <= idx_i - 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Deck storage
  // ---------------------------------------------------------------------------
  // NOTE: the deck array is reset explicitly because identity order after
  // reset is architecturally visible (unshuffled deals return 0,1,2,...).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DECK_SIZE; k++) deck[k] <= 6'(k);
    end else if (load_identity) begin
      for (int k = 0; k < DECK_SIZE; k++) deck[k] <= 6'(k);
    end else if (state == SHUF_RUN && swap_ok) begin
      // When j == i both writes carry the same value, so the swap is a no-op.
      deck[idx_i] <= deck[j_idx];
      deck[j_idx] <= deck[idx_i];
    end
  end

  // ---------------------------------------------------------------------------
  // Deal pointer, remaining count and card output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= 6'd0;
      remaining    <= FULL_COUNT;
      card_valid_q <= 1'b0;
      card_q       <= 6'd0;
      rank_q       <= 4'd0;
      value_q      <= 4'd0;
    end else begin
      card_valid_q <= deliver;

      // Refill on entry to SHUF_DONE so the count is already 52 while the
      // done pulse is visible.
      if (state == SHUF_RUN && last_swap) begin
        ptr       <= 6'd0;
        remaining <= FULL_COUNT;
      end else if (deliver) begin
        ptr       <= ptr + 6'd1;
        remaining <= remaining - 6'd1;
      end

      // Card fields hold their last value between deals.
      if (deliver) begin
        card_q  <= head_card;
        rank_q  <= head_rank;
        value_q <= value_of(head_rank);
      end
    end
  end

`ifdef AUTO_RESHUFFLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              pending <= 1'b0;
    else if (auto_start)                  pending <= 1'b1;
    else if (state == SHUF_DONE && pending) pending <= 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.card_valid      = card_valid_q;
  assign bus.card            = card_q;
  assign bus.card_rank       = rank_q;
  assign bus.card_value      = value_q;
  assign bus.shuffle_busy    = busy_q;
  assign bus.shuffle_done    = done_q;
  assign bus.cards_remaining = remaining;
  assign bus.deck_empty      = (remaining == 6'd0);
  assign bus.deck_low        = (remaining < LOW_LEVEL);

endmodule
